multicycle_ctrl_fsm: RTL and testbench

// Moore-style control state machine for the multicycle MIPS datapath. Sequences
// the shared ALU, the ALU operand muxes (ALUSrcA / ALUSrcB), the register file,
// the unified memory and the PC/IR enables across FETCH..WRITEBACK states.

---
 rtl/mips_ctrl_pkg.sv | 99 +++++++++
 rtl/mem_wait_timer.sv | 26 ++
 rtl/multicycle_ctrl_fsm.sv | 117 +++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller, datapath muxes and ALU control.
// Also holds the per-state Moore output table used by the FSM.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_RWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [1:0] {SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_t;
   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_RSVD} alu_op_t;
   typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_RSVD} pc_src_t;

   typedef struct packed {
      logic       pc_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       instr_done;
   } ctrl_t;

   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

   // Handshake-qualified strobes (ir_write, FETCH pc_write, BRANCH pc_write,
   // MEMWR instr_done) are added in the FSM; this table holds only the
   // state-only part.
   function automatic ctrl_t ctrl_for(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
         end
         S_DECODE:  c.alu_src_b = SRCB_IMM_SH2;
         S_MEMADR, S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            c.reg_dst    = 1'b1;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a  = 1'b1;
            c.alu_op     = ALU_SUB;
            c.pc_src     = PC_ALUOUT;
            c.instr_done = 1'b1;
         end
         S_ADDIWB: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_JUMP: begin
            c.pc_src     = PC_JUMP;
            c.pc_write   = 1'b1;
            c.instr_done = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready and flags the cycle in
// which the wait budget is exhausted with memory still not ready.
module mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   input  logic mem_ready,
   output logic timeout
);

   localparam logic [7:0] TC = 8'(MEM_WAIT_MAX - 1);

   logic [7:0] wait_cnt;

   // Held at zero outside the wait states, so every entry starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      wait_cnt <= '0;
      else if (!waiting || mem_ready) wait_cnt <= '0;
      else                          wait_cnt <= wait_cnt + 8'd1;
   end

   assign timeout = waiting && !mem_ready && (wait_cnt == TC);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multicycle MIPS datapath with memory-ready
// handshake, illegal-opcode flag and sticky timeout halt.
//
// state  | meaning
// IDLE   | one cycle after reset
// FETCH  | read instruction at PC, PC+4 and IR load on mem_ready
// DECODE | precompute branch target, dispatch on opcode
// MEMADR | compute load/store address
// MEMRD  | load read, wait on mem_ready
// MEMWB  | load writeback to rt
// MEMWR  | store write, wait on mem_ready
// EXEC   | R-type ALU operation
// RWB    | R-type writeback to rd
// BRANCH | compare, PC <= ALUOut when zero
// ADDIEX | ADDI add immediate
// ADDIWB | ADDI writeback to rt
// JUMP   | PC <= jump target
// HALT   | memory timeout, terminal until rst
module multicycle_ctrl_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       halted
);

   state_t state, state_nxt;
   ctrl_t  ctrl_q;
   logic   waiting, timeout;

   assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

   mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .waiting   (waiting),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   state_nxt = S_FETCH;
         S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
                   else if (timeout) state_nxt = S_HALT;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_EXEC;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_J:         state_nxt = S_JUMP;
               default:      state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
                   else if (timeout) state_nxt = S_HALT;
         S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
                   else if (timeout) state_nxt = S_HALT;
         S_EXEC:   state_nxt = S_RWB;
         S_ADDIEX: state_nxt = S_ADDIWB;
         S_MEMWB, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         ctrl_q <= '0;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         ctrl_q <= ctrl_for(state_nxt);
         halted <= (state_nxt == S_HALT);
      end
   end

   assign ir_write   = (state == S_FETCH) && mem_ready;
   assign pc_write   = ctrl_q.pc_write || ir_write || ((state == S_BRANCH) && zero);
   assign instr_done = ctrl_q.instr_done || ((state == S_MEMWR) && mem_ready);
   assign illegal_op = (state == S_DECODE) && !is_legal(opcode);
   assign iord       = ctrl_q.iord;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign reg_dst    = ctrl_q.reg_dst;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign reg_write  = ctrl_q.reg_write;
   assign alu_src_a  = ctrl_q.alu_src_a;
   assign alu_src_b  = ctrl_q.alu_src_b;
   assign alu_op     = ctrl_q.alu_op;
   assign pc_src     = ctrl_q.pc_src;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: each driven cycle pushes the expected
// output vector; a negedge monitor captures the actual vector for comparison.
module tb_multicycle_ctrl_fsm;

   localparam logic [5:0] T_RTYPE = 6'b000000;
   localparam logic [5:0] T_LW    = 6'b100011;
   localparam logic [5:0] T_SW    = 6'b101011;
   localparam logic [5:0] T_BEQ   = 6'b000100;
   localparam logic [5:0] T_ADDI  = 6'b001000;
   localparam logic [5:0] T_J     = 6'b000010;
   localparam logic [5:0] T_BAD   = 6'b111111;

   // {pc_write,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
   //  alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_src[1:0],instr_done,illegal_op,halted}
   function automatic logic [17:0] fv(
      input logic pcw, input logic io, input logic mrd, input logic mwr,
      input logic irw, input logic rd, input logic m2r, input logic rw,
      input logic sa, input logic [1:0] sb, input logic [1:0] op,
      input logic [1:0] ps, input logic dn, input logic il, input logic hl);
      return {pcw, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, op, ps, dn, il, hl};
   endfunction

   localparam logic [17:0] E_ZERO = 18'd0;
   localparam logic [17:0] E_FW   = fv(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
   localparam logic [17:0] E_FR   = fv(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
   localparam logic [17:0] E_DEC  = fv(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
   localparam logic [17:0] E_ILL  = fv(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1,0);
   localparam logic [17:0] E_MADR = fv(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
   localparam logic [17:0] E_MRD  = fv(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
   localparam logic [17:0] E_MWB  = fv(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0,0);
   localparam logic [17:0] E_MWR  = fv(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
   localparam logic [17:0] E_MWRD = fv(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,0);
   localparam logic [17:0] E_EXEC = fv(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
   localparam logic [17:0] E_RWB  = fv(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0,0);
   localparam logic [17:0] E_BRT  = fv(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,0);
   localparam logic [17:0] E_BRF  = fv(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,0);
   localparam logic [17:0] E_AEX  = fv(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
   localparam logic [17:0] E_AWB  = fv(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0,0);
   localparam logic [17:0] E_JMP  = fv(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);
   localparam logic [17:0] E_HALT = fv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,1);

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       zero, mem_ready;
   logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
   logic       reg_write, alu_src_a, instr_done, illegal_op, halted;
   logic [1:0] alu_src_b, alu_op, pc_src;

   int total = 0;
   int bad   = 0;
   logic capture = 1'b0;
   logic [17:0] exp_q[$];
   logic [17:0] obs_q[$];

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.MEM_WAIT_MAX(15)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
      .illegal_op(illegal_op), .halted(halted)
   );

   always @(negedge clk)
      if (capture)
         obs_q.push_back({pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
                          mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                          pc_src, instr_done, illegal_op, halted});

   // One clock of stimulus; the expected vector for this cycle goes on the scoreboard.
   task automatic cyc(input logic r, input logic mr, input logic z,
                      input logic [5:0] op, input logic [17:0] e);
      rst = r; mem_ready = mr; zero = z; opcode = op;
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [17:0] e, o; int idx = 0;
      capture = 1'b1;
      cyc(1, 1, 0, T_J, E_ZERO);
      cyc(1, 1, 0, T_J, E_ZERO);
      cyc(0, 1, 0, T_J, E_ZERO);
      cyc(0, 1, 0, T_J, E_FR);
      cyc(0, 1, 0, T_J, E_DEC);
      cyc(0, 1, 0, T_J, E_JMP);
      capture = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL reset idx=%0d got=none exp=%b", idx, e); end
         else begin o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL reset idx=%0d got=%b exp=%b", idx, o, e); end end
         idx++;
      end
      obs_q.delete();
   endtask

   task automatic test_lw();
      logic [17:0] e, o; int idx = 0;
      capture = 1'b1;
      cyc(0, 1, 0, T_LW, E_FR);
      cyc(0, 1, 0, T_LW, E_DEC);
      cyc(0, 1, 0, T_LW, E_MADR);
      cyc(0, 1, 0, T_LW, E_MRD);
      cyc(0, 1, 0, T_LW, E_MWB);
      capture = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL lw idx=%0d got=none exp=%b", idx, e); end
         else begin o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL lw idx=%0d got=%b exp=%b", idx, o, e); end end
         idx++;
      end
      obs_q.delete();
   endtask

   task automatic test_sw();
      logic [17:0] e, o; int idx = 0;
      capture = 1'b1;
      cyc(0, 1, 0, T_SW, E_FR);
      cyc(0, 0, 0, T_SW, E_DEC);
      cyc(0, 0, 0, T_SW, E_MADR);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, T_SW, E_MWR);
      cyc(0, 1, 0, T_SW, E_MWRD);
      capture = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL sw idx=%0d got=none exp=%b", idx, e); end
         else begin o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL sw idx=%0d got=%b exp=%b", idx, o, e); end end
         idx++;
      end
      obs_q.delete();
   endtask

   task automatic test_beq();
      logic [17:0] e, o; int idx = 0;
      capture = 1'b1;
      cyc(0, 1, 1, T_BEQ, E_FR);
      cyc(0, 1, 1, T_BEQ, E_DEC);
      cyc(0, 1, 1, T_BEQ, E_BRT);
      cyc(0, 1, 0, T_BEQ, E_FR);
      cyc(0, 1, 1, T_BEQ, E_DEC);
      cyc(0, 1, 0, T_BEQ, E_BRF);
      capture = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL beq idx=%0d got=none exp=%b", idx, e); end
         else begin o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL beq idx=%0d got=%b exp=%b", idx, o, e); end end
         idx++;
      end
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [17:0] e, o; int idx = 0;
      capture = 1'b1;
      cyc(0, 1, 0, T_RTYPE, E_FR);
      cyc(0, 1, 0, T_RTYPE, E_DEC);
      cyc(0, 1, 0, T_RTYPE, E_EXEC);
      cyc(0, 1, 0, T_RTYPE, E_RWB);
      cyc(0, 1, 0, T_ADDI,  E_FR);
      cyc(0, 1, 0, T_ADDI,  E_DEC);
      cyc(0, 1, 0, T_ADDI,  E_AEX);
      cyc(0, 1, 0, T_ADDI,  E_AWB);
      cyc(0, 1, 0, T_J,     E_FR);
      cyc(0, 1, 0, T_J,     E_DEC);
      cyc(0, 1, 0, T_J,     E_JMP);
      capture = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL b2b idx=%0d got=none exp=%b", idx, e); end
         else begin o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL b2b idx=%0d got=%b exp=%b", idx, o, e); end end
         idx++;
      end
      obs_q.delete();
   endtask

   task automatic test_illegal();
      logic [17:0] e, o; int idx = 0;
      capture = 1'b1;
      cyc(0, 1, 0, T_BAD, E_FR);
      cyc(0, 1, 0, T_BAD, E_ILL);
      cyc(0, 0, 0, T_BAD, E_FW);
      cyc(0, 1, 0, T_BAD, E_FR);
      cyc(0, 1, 0, T_J,   E_DEC);
      cyc(0, 1, 0, T_J,   E_JMP);
      capture = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL illegal idx=%0d got=none exp=%b", idx, e); end
         else begin o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL illegal idx=%0d got=%b exp=%b", idx, o, e); end end
         idx++;
      end
      obs_q.delete();
   endtask

   // 14 waiting cycles is one short of the budget: no halt.
   task automatic test_wait_boundary();
      logic [17:0] e, o; int idx = 0;
      capture = 1'b1;
      for (int i = 0; i < 14; i++) cyc(0, 0, 0, T_LW, E_FW);
      cyc(0, 1, 0, T_LW, E_FR);
      cyc(0, 1, 0, T_LW, E_DEC);
      cyc(0, 1, 0, T_LW, E_MADR);
      for (int i = 0; i < 14; i++) cyc(0, 0, 0, T_LW, E_MRD);
      cyc(0, 1, 0, T_LW, E_MRD);
      cyc(0, 1, 0, T_LW, E_MWB);
      capture = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL wait_bnd idx=%0d got=none exp=%b", idx, e); end
         else begin o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL wait_bnd idx=%0d got=%b exp=%b", idx, o, e); end end
         idx++;
      end
      obs_q.delete();
   endtask

   task automatic test_timeout();
      logic [17:0] e, o; int idx = 0;
      capture = 1'b1;
      for (int i = 0; i < 15; i++) cyc(0, 0, 0, T_LW, E_FW);
      for (int i = 0; i < 5; i++)  cyc(0, 1, 1, T_LW, E_HALT);
      capture = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL timeout idx=%0d got=none exp=%b", idx, e); end
         else begin o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL timeout idx=%0d got=%b exp=%b", idx, o, e); end end
         idx++;
      end
      obs_q.delete();
   endtask

   // Leaves HALT via rst, then aborts a load mid-read before its writeback.
   task automatic test_reset_mid();
      logic [17:0] e, o; int idx = 0;
      capture = 1'b1;
      cyc(1, 1, 0, T_LW, E_ZERO);
      cyc(0, 1, 0, T_LW, E_ZERO);
      cyc(0, 1, 0, T_LW, E_FR);
      cyc(0, 1, 0, T_LW, E_DEC);
      cyc(0, 1, 0, T_LW, E_MADR);
      cyc(0, 0, 0, T_LW, E_MRD);
      cyc(1, 1, 0, T_LW, E_ZERO);
      cyc(0, 1, 0, T_LW, E_ZERO);
      cyc(0, 1, 0, T_LW, E_FR);
      capture = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL rst_mid idx=%0d got=none exp=%b", idx, e); end
         else begin o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL rst_mid idx=%0d got=%b exp=%b", idx, o, e); end end
         idx++;
      end
      obs_q.delete();
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0;
      @(posedge clk); #1;
      test_reset();
      test_lw();
      test_sw();
      test_beq();
      test_back_to_back();
      test_illegal();
      test_wait_boundary();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
